data_mem: RTL and testbench

Data-memory stage of the MIPS32 pipeline: a single-port synchronous RAM that services one load or store per cycle from the EX/MEM pipeline register and returns aligned, sign- or zero-extended load data to MEM/WB one cycle later. It sits between `ex_mem` and `mem_wb` and drives the currently unconnected `mem_mem_data` path. It performs byte-lane steering for byte, halfword and word accesses, blocks misaligned and out-of-range accesses, and records the first fault.

---
 rtl/data_mem.sv | 173 +++++++++++++++++
 tb/tb_data_mem.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/data_mem.sv
// Data-memory stage: single-port synchronous RAM with byte-lane steering,
// sign/zero-extended loads one cycle after the request, and fault capture.
module data_mem #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic        mem_signed,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] wb_rdata,
    output logic        wb_rvalid,
    output logic        mem_err,
    output logic [31:0] err_addr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [DEPTH_LOG2-1:0] word_idx;
    logic [1:0]            byte_off;
    logic                  fault;
    logic                  store_ok;
    logic                  load_ok;
    logic [3:0]            lane_we;
    logic [31:0]           rd_word;

    assign word_idx = mem_addr[DEPTH_LOG2+1:2];
    assign byte_off = mem_addr[1:0];

    always_comb begin
        fault = 1'b0;
        case (mem_size)
            SZ_BYTE: fault = 1'b0;
            SZ_HALF: fault = mem_addr[0];
            SZ_WORD: fault = (mem_addr[1:0] != 2'b00);
            default: fault = 1'b1;
        endcase
        // No wrap: any address bit above the array range is an error.
        if (mem_addr[31:DEPTH_LOG2+2] != '0) begin
            fault = 1'b1;
        end
    end

    // Reset wins over a coincident request, so the array is never touched under rst.
    assign store_ok = mem_ce &  mem_we & ~fault & ~rst;
    assign load_ok  = mem_ce & ~mem_we & ~fault & ~rst;

    always_comb begin
        lane_we = 4'b0000;
        if (store_ok) begin
            case (mem_size)
                SZ_BYTE: lane_we = 4'b0001 << byte_off;
                SZ_HALF: lane_we = byte_off[1] ? 4'b1100 : 4'b0011;
                default: lane_we = 4'b1111;
            endcase
        end
    end

    // One independent byte-wide RAM per lane keeps each lane a plain single-writer array.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : lane_g
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_wdata;
            logic [7:0] rd_byte_q;

            always_comb begin
                lane_wdata = mem_wdata[8*gi +: 8];
                case (mem_size)
                    SZ_BYTE: lane_wdata = mem_wdata[7:0];
                    SZ_HALF: lane_wdata = ((gi % 2) == 1) ? mem_wdata[15:8] : mem_wdata[7:0];
                    default: lane_wdata = mem_wdata[8*gi +: 8];
                endcase
            end

            always_ff @(posedge clk) begin
                if (lane_we[gi]) begin
                    lane_mem[word_idx] <= lane_wdata;
                end
                if (load_ok) begin
                    rd_byte_q <= lane_mem[word_idx];
                end
            end

            assign rd_word[8*gi +: 8] = rd_byte_q;
        end
    endgenerate

    logic        rvalid_q,   rvalid_d;
    logic        err_q,      err_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic        sticky_q,   sticky_d;
    logic [1:0]  off_q,      off_d;
    logic [1:0]  size_q,     size_d;
    logic        signed_q,   signed_d;
    logic        loaded_q,   loaded_d;

    always_comb begin
        rvalid_d   = load_ok;
        err_d      = mem_ce & fault;
        err_addr_d = err_addr_q;
        sticky_d   = sticky_q;
        off_d      = off_q;
        size_d     = size_q;
        signed_d   = signed_q;
        loaded_d   = loaded_q;
        if (mem_ce && fault && !sticky_q) begin
            err_addr_d = mem_addr;
            sticky_d   = 1'b1;
        end
        if (load_ok) begin
            off_d    = byte_off;
            size_d   = mem_size;
            signed_d = mem_signed;
            loaded_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            sticky_q   <= 1'b0;
            off_q      <= '0;
            size_q     <= '0;
            signed_q   <= 1'b0;
            loaded_q   <= 1'b0;
        end else begin
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            sticky_q   <= sticky_d;
            off_q      <= off_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            loaded_q   <= loaded_d;
        end
    end

    // The lane read registers are not reset; loaded_q forces a zero result until the first load.
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] ext_data;

    always_comb begin
        case (off_q)
            2'd0:    sel_byte = rd_word[7:0];
            2'd1:    sel_byte = rd_word[15:8];
            2'd2:    sel_byte = rd_word[23:16];
            default: sel_byte = rd_word[31:24];
        endcase
        sel_half = off_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (size_q)
            SZ_BYTE: ext_data = {{24{signed_q & sel_byte[7]}}, sel_byte};
            SZ_HALF: ext_data = {{16{signed_q & sel_half[15]}}, sel_half};
            default: ext_data = rd_word;
        endcase
    end

    assign wb_rdata  = loaded_q ? ext_data : 32'h0;
    assign wb_rvalid = rvalid_q;
    assign mem_err   = err_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: each driven cycle pushes its expected
// outputs, and the negedge monitor pops and compares them one cycle later.
module tb_data_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_ce = 1'b0;
    logic        mem_we = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic        mem_signed = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] wb_rdata;
    logic        wb_rvalid;
    logic        mem_err;
    logic [31:0] err_addr;

    data_mem #(.DEPTH_LOG2(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_ce     (mem_ce),
        .mem_we     (mem_we),
        .mem_size   (mem_size),
        .mem_signed (mem_signed),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .wb_rdata   (wb_rdata),
        .wb_rvalid  (wb_rvalid),
        .mem_err    (mem_err),
        .err_addr   (err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] eaddr;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    // Bench-side view of what the outputs must hold between loads.
    logic [31:0] held_rdata = '0;
    logic        sticky     = 1'b0;
    logic [31:0] first_addr = '0;

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] W = 2'b10;
    localparam logic [1:0] R = 2'b11;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            $display("txn %-14s rvalid=%0b rdata=0x%08h err=%0b err_addr=0x%08h",
                     e.tag, wb_rvalid, wb_rdata, mem_err, err_addr);
            check_val({e.tag, ".rvalid"},   {31'b0, wb_rvalid}, {31'b0, e.rvalid});
            check_val({e.tag, ".err"},      {31'b0, mem_err},   {31'b0, e.err});
            check_val({e.tag, ".rdata"},    wb_rdata,           e.rdata);
            check_val({e.tag, ".err_addr"}, err_addr,           e.eaddr);
        end
    end

    // f: this access must fault; ed: expected load result for a good load.
    task automatic acc(input logic r, input logic c, input logic w, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] wd,
                       input logic f, input logic [31:0] ed, input string tag);
        exp_t e;
        @(negedge clk);
        #1;
        rst        = r;
        mem_ce     = c;
        mem_we     = w;
        mem_size   = sz;
        mem_signed = sg;
        mem_addr   = a;
        mem_wdata  = wd;
        e.tag    = tag;
        e.rvalid = 1'b0;
        e.err    = 1'b0;
        if (r) begin
            held_rdata = '0;
            sticky     = 1'b0;
            first_addr = '0;
        end else if (c && f) begin
            e.err = 1'b1;
            if (!sticky) begin
                sticky     = 1'b1;
                first_addr = a;
            end
        end else if (c && !w) begin
            e.rvalid   = 1'b1;
            held_rdata = ed;
        end
        e.rdata = held_rdata;
        e.eaddr = first_addr;
        sb.push_back(e);
    endtask

    initial begin
        // reset and idle
        acc(1, 0, 0, B, 0, 32'h0,  32'h0, 0, 0, "rst0");
        acc(1, 0, 0, B, 0, 32'h0,  32'h0, 0, 0, "rst1");
        acc(0, 0, 0, B, 0, 32'h0,  32'h0, 0, 0, "idle0");
        // initialise words read later
        acc(0, 1, 1, W, 0, 32'h0,  32'h12345678, 0, 0, "sw_0x0");
        acc(0, 1, 1, W, 0, 32'h20, 32'hCAFEF00D, 0, 0, "sw_0x20");
        // word access, back-to-back store->load
        acc(0, 1, 1, W, 0, 32'h10, 32'h11223344, 0, 0, "sw_0x10");
        acc(0, 1, 0, W, 0, 32'h10, 32'h0, 0, 32'h11223344, "lw_0x10");
        acc(0, 0, 0, B, 0, 32'h0,  32'h0, 0, 0, "idle1");
        // byte access
        acc(0, 1, 0, B, 1, 32'h13, 32'h0, 0, 32'h00000011, "lb_0x13");
        acc(0, 1, 1, B, 0, 32'h12, 32'h80, 0, 0, "sb_0x12");
        acc(0, 1, 0, B, 1, 32'h12, 32'h0, 0, 32'hFFFFFF80, "lb_0x12");
        acc(0, 1, 0, B, 0, 32'h12, 32'h0, 0, 32'h00000080, "lbu_0x12");
        acc(0, 1, 0, W, 0, 32'h10, 32'h0, 0, 32'h11803344, "lw_0x10b");
        // halfword access
        acc(0, 1, 1, W, 0, 32'h14, 32'h0, 0, 0, "sw_0x14");
        acc(0, 1, 1, H, 0, 32'h16, 32'h1234BEEF, 0, 0, "sh_0x16");
        acc(0, 1, 0, H, 0, 32'h16, 32'h0, 0, 32'h0000BEEF, "lhu_0x16");
        acc(0, 1, 0, H, 1, 32'h16, 32'h0, 0, 32'hFFFFBEEF, "lh_0x16");
        acc(0, 1, 0, W, 0, 32'h14, 32'h0, 0, 32'hBEEF0000, "lw_0x14");
        acc(0, 1, 0, B, 0, 32'h14, 32'h0, 0, 32'h00000000, "lbu_0x14");
        acc(0, 1, 0, B, 1, 32'h17, 32'h0, 0, 32'hFFFFFFBE, "lb_0x17");
        acc(0, 1, 0, H, 0, 32'h12, 32'h0, 0, 32'h00001180, "lhu_0x12");
        // misalignment and sticky fault address
        acc(0, 1, 0, W, 0, 32'h11, 32'h0, 1, 0, "lw_0x11");
        acc(0, 1, 1, W, 0, 32'h21, 32'hDEADBEEF, 1, 0, "sw_0x21");
        acc(0, 1, 0, W, 0, 32'h20, 32'h0, 0, 32'hCAFEF00D, "lw_0x20");
        acc(0, 1, 0, H, 1, 32'h13, 32'h0, 1, 0, "lh_0x13");
        // out of range and reserved size
        acc(0, 1, 1, W, 0, 32'h1000, 32'hFFFFFFFF, 1, 0, "sw_0x1000");
        acc(0, 1, 0, W, 0, 32'h0,  32'h0, 0, 32'h12345678, "lw_0x0");
        acc(0, 1, 0, R, 0, 32'h0,  32'h0, 1, 0, "lrsv_0x0");
        acc(0, 1, 0, B, 0, 32'h80000000, 32'h0, 1, 0, "lbu_hi");
        // reset collides with a store
        acc(1, 1, 1, W, 0, 32'h10, 32'hFFFFFFFF, 0, 0, "rst_sw");
        acc(0, 0, 0, B, 0, 32'h0,  32'h0, 0, 0, "idle2");
        acc(0, 1, 0, W, 0, 32'h10, 32'h0, 0, 32'h11803344, "lw_0x10c");
        acc(0, 1, 0, H, 0, 32'h15, 32'h0, 1, 0, "lh_0x15");
        acc(0, 1, 0, B, 1, 32'h16, 32'h0, 0, 32'hFFFFFFEF, "lb_0x16");

        @(negedge clk);
        #1;
        mem_ce = 1'b0;
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            check_val("drain", sb.size(), 0);
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
